// File: rtl/pixel_sequencer.sv
// pixel_sequencer: frame sequencer for a pixel array (erase, expose, ramp convert, read, stream out)
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset; returns to IDLE with all outputs low
//   start          begins a frame when sampled high in IDLE
//   continuous     sampled on the last stream handshake; high chains straight into the next frame
//   expose_cycles  exposure length in cycles (0 behaves as 1), latched at each frame start
//   erase/expose/convert/read  phase strobes, one per matching state
//   dac_data       ramp count, 0..2^DATA_W-1 during CONVERT, 0 elsewhere
//   pix_bus        N_PIX packed pixel samples, captured at the end of READ
//   out_data/out_ch/out_valid/out_ready  valid/ready stream of captured samples, channel 0 first
//   busy           high whenever the sequencer is not IDLE
//   frame_done     high on the handshake of the last channel
//   frame_cnt      frames completed, wraps at 16 bits (only with PIXEL_SEQ_FRAME_COUNT_EN)
module pixel_sequencer #(
   parameter int N_PIX     = 4,
   parameter int DATA_W    = 8,
   parameter int ERASE_CYC = 5,
   localparam int CHW      = (N_PIX > 1) ? $clog2(N_PIX) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    continuous,
   input  logic [15:0]             expose_cycles,
   output logic                    erase,
   output logic                    expose,
   output logic                    convert,
   output logic                    read,
   output logic [DATA_W-1:0]       dac_data,
   input  logic [N_PIX*DATA_W-1:0] pix_bus,
   output logic [DATA_W-1:0]       out_data,
   output logic [CHW-1:0]          out_ch,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    busy,
`ifdef PIXEL_SEQ_FRAME_COUNT_EN
   output logic [15:0]             frame_cnt,
`endif
   output logic                    frame_done
);
   typedef enum logic [2:0] {IDLE, ERASE, EXPOSE, CONVERT, READ, STREAM} state_t;
   localparam logic [CHW-1:0] LAST_CH = CHW'(N_PIX - 1);
   state_t state, next;
   logic [15:0] cnt, exp_len, exp_last;
   logic [DATA_W-1:0] dac;
   logic [CHW-1:0] idx;
   logic [DATA_W-1:0] cap [N_PIX];
   logic frame_start;
   // exposure of 0 is stretched to a single cycle
   assign exp_last = (exp_len == 16'd0) ? 16'd0 : exp_len - 16'd1;
   // expose_cycles is latched on every entry into ERASE, including a continuous restart
   assign frame_start = (state == IDLE && start) || (frame_done && continuous);
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else       state <= next;
   always_comb begin
      next       = state;
      erase      = 1'b0;
      expose     = 1'b0;
      convert    = 1'b0;
      read       = 1'b0;
      dac_data   = '0;
      out_data   = '0;
      out_ch     = '0;
      out_valid  = 1'b0;
      frame_done = 1'b0;
      busy       = state != IDLE;
      case (state)
         IDLE:    next = start ? ERASE : IDLE;
         ERASE: begin
            erase = 1'b1;
            if (cnt == 16'(ERASE_CYC - 1)) next = EXPOSE;
         end
         EXPOSE: begin
            expose = 1'b1;
            if (cnt == exp_last) next = CONVERT;
         end
         CONVERT: begin
            convert  = 1'b1;
            dac_data = dac;
            if (dac == '1) next = READ;
         end
         READ: begin
            read = 1'b1;
            next = STREAM;
         end
         STREAM: begin
            out_valid = 1'b1;
            out_data  = cap[idx];
            out_ch    = idx;
            if (out_ready && idx == LAST_CH) begin
               frame_done = 1'b1;
               next       = continuous ? ERASE : IDLE;
            end
         end
         default: next = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cnt     <= '0;
         dac     <= '0;
         idx     <= '0;
         exp_len <= '0;
         for (int k = 0; k < N_PIX; k++) cap[k] <= '0;
      end else begin
         // phase timer restarts on every state change
         cnt <= (next == state && (state == ERASE || state == EXPOSE)) ? cnt + 16'd1 : 16'd0;
         // ramp wraps to 0 on the last CONVERT cycle, so it is idle at 0 outside CONVERT
         dac <= convert ? dac + 1'b1 : '0;
         if (frame_start) exp_len <= expose_cycles;
         if (read)
            for (int k = 0; k < N_PIX; k++) cap[k] <= pix_bus[k*DATA_W +: DATA_W];
         if (out_valid && out_ready) idx <= (idx == LAST_CH) ? '0 : CHW'(idx + 1'b1);
      end
`ifdef PIXEL_SEQ_FRAME_COUNT_EN
   always_ff @(posedge clk or posedge reset)
      if (reset)           frame_cnt <= '0;
      else if (frame_done) frame_cnt <= frame_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_pixel_sequencer.sv
// tb_pixel_sequencer: randomized self-checking bench for pixel_sequencer against a frame timeline model
module tb_pixel_sequencer;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        continuous = 1'b0;
   logic [15:0] expose_cycles = '0;
   logic        erase, expose, convert, read;
   logic [7:0]  dac_data;
   logic [31:0] pix_bus = '0;
   logic [7:0]  out_data;
   logic [1:0]  out_ch;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        busy, frame_done;
   int          total = 0;
   int          bad = 0;
   int          frames = 0;
`ifdef PIXEL_SEQ_FRAME_COUNT_EN
   logic [15:0] frame_cnt;
`endif

   pixel_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .continuous(continuous),
      .expose_cycles(expose_cycles), .erase(erase), .expose(expose),
      .convert(convert), .read(read), .dac_data(dac_data), .pix_bus(pix_bus),
      .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy),
`ifdef PIXEL_SEQ_FRAME_COUNT_EN
      .frame_cnt(frame_cnt),
`endif
      .frame_done(frame_done));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] all_out;
      return {8'(dac_data), 8'(out_data), 2'(out_ch), 1'(out_valid), 1'(busy),
              1'(frame_done), 1'(erase), 1'(expose), 1'(convert), 1'(read), 9'd0};
   endfunction

   // One frame. Timeline: cycle t=1 is the first ERASE cycle; ERASE t=1..5, EXPOSE el cycles,
   // CONVERT 256 cycles with dac = cycles into CONVERT, READ one cycle, then STREAM.
   // mode 0: out_ready always high, 1: random, 2: low for 3 cycles on channel 1.
   task automatic frame(input int e, input bit via_start, input bit cont, input int ne,
                        input int mode, input logic [31:0] pix);
      int el, pre, k, hold, beats;
      logic [31:0] pv;
      logic [7:0] w [4];
      el = (e == 0) ? 1 : e;
      pre = 5 + el + 257;
      if (via_start) begin
         start = 1'b1;
         expose_cycles = 16'(e);
         #1;
         chk("idle_busy", 32'(busy), 32'd0);
         step;
      end
      pv = (pix != 0) ? pix : $urandom;
      for (int i = 0; i < 4; i++) w[i] = pv[i*8 +: 8];
      for (int t = 1; t <= pre; t++) begin
         start = 1'($urandom);
         expose_cycles = 16'($urandom);
         pix_bus = (t == pre) ? pv : $urandom;
         out_ready = 1'($urandom);
         continuous = 1'($urandom);
         #1;
         chk("strobes", 32'({erase, expose, convert, read}),
             32'({t <= 5, t > 5 && t <= 5 + el, t > 5 + el && t < pre, t == pre}));
         chk("dac", 32'(dac_data), (t > 5 + el && t < pre) ? 32'(t - 6 - el) : 32'd0);
         chk("pre_stream", 32'({out_valid, frame_done, busy}), 32'd1);
         step;
      end
      k = 0; hold = 0; beats = 0;
      continuous = cont;
      expose_cycles = 16'(ne);
      while (k < 4 && beats < 64) begin
         start = 1'($urandom);
         pix_bus = $urandom;
         out_ready = (mode == 0) ? 1'b1 : (mode == 2) ? (k != 1 || hold >= 3) : ($urandom % 3 != 0);
         if (k == 1 && !out_ready) hold++;
         #1;
         chk("valid", 32'(out_valid), 32'd1);
         chk("ch", 32'(out_ch), 32'(k));
         chk("data", 32'(out_data), 32'(w[k]));
         chk("stream_strobes", 32'({erase, expose, convert, read, dac_data}), 32'd0);
         chk("frame_done", 32'(frame_done), 32'(out_ready && k == 3));
         beats++;
         if (out_ready) k++;
         step;
      end
      if (k < 4) chk("stream_timeout", 32'(k), 32'd4);
      if (mode != 1) chk("stream_len", 32'(beats), (mode == 2) ? 32'd7 : 32'd4);
      start = 1'b0;
      out_ready = 1'b0;
      #1;
      frames++;
      chk("after_frame", 32'({busy, erase, out_valid, frame_done}), 32'({cont, cont, 2'b00}));
`ifdef PIXEL_SEQ_FRAME_COUNT_EN
      chk("frame_cnt", 32'(frame_cnt), 32'(frames));
`endif
   endtask

   initial begin
      bit prev_cont;
      int e, ne;
      bit c;
      repeat (2) step;
      chk("reset_outputs", all_out(), 32'd0);
      reset = 1'b0;
      step;
      chk("no_spurious_start", 32'(busy), 32'd0);
      frame(10, 1'b1, 1'b0, 0, 0, 32'h44332211);
      frame(0, 1'b1, 1'b0, 0, 2, 32'h0);
      frame(3, 1'b1, 1'b1, 7, 1, 32'h0);
      frame(7, 1'b0, 1'b0, 0, 0, 32'h0);
      prev_cont = 1'b0;
      e = $urandom_range(0, 20);
      for (int i = 0; i < 5; i++) begin
         ne = $urandom_range(0, 20);
         c = 1'($urandom);
         frame(e, !prev_cont, c, ne, 1, 32'h0);
         prev_cont = c;
         e = ne;
      end
      if (prev_cont) frame(e, 1'b0, 1'b0, 0, 0, 32'h0);
      // asynchronous reset mid-CONVERT at dac=100
      start = 1'b1;
      expose_cycles = 16'd4;
      step;
      start = 1'b0;
      repeat (109) step;
      chk("dac_at_100", 32'(dac_data), 32'd100);
      reset = 1'b1;
      #1;
      chk("reset_mid_convert", all_out(), 32'd0);
      step;
      reset = 1'b0;
      #1;
      chk("idle_after_reset", 32'(busy), 32'd0);
      step;
      chk("no_start_after_reset", 32'(busy), 32'd0);
      // asynchronous reset mid-STREAM with the first sample pending
      start = 1'b1;
      expose_cycles = 16'd1;
      pix_bus = 32'h5A5A5A5A;
      step;
      start = 1'b0;
      repeat (263) step;
      chk("stream_before_reset", 32'({out_valid, out_data}), 32'h15A);
      reset = 1'b1;
      #1;
      chk("reset_mid_stream", all_out(), 32'd0);
      step;
      reset = 1'b0;
      step;
      chk("idle_end", 32'(busy), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pixel_sequencer.md
PIXEL_SEQUENCER -- requirements
Module: pixel_sequencer

Interface
REQ-001 SHALL have parameter N_PIX, default 4, number of pixel channels on the readout bus.
REQ-002 SHALL have parameter DATA_W, default 8, pixel sample and ramp-counter width.
REQ-003 SHALL have parameter ERASE_CYC, default 5, ERASE state length in cycles, legal range 1..255.
REQ-004 SHALL have port clk  input  1  single system clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  begin one frame when sampled high in IDLE.
REQ-007 SHALL have port continuous  input  1  sampled at frame end; high starts the next frame immediately.
REQ-008 SHALL have port expose_cycles  input  16  exposure length in cycles, latched on start.
REQ-009 SHALL have ports erase, expose, convert, read  output  1 each  pixel-array phase strobes.
REQ-010 SHALL have port dac_data  output  DATA_W  digital ramp count driven to the pixel array.
REQ-011 SHALL have port pix_bus  input  N_PIX*DATA_W  pixel samples; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-012 SHALL have port out_data  output  DATA_W  streamed pixel sample.
REQ-013 SHALL have port out_ch  output  clog2(N_PIX), minimum 1  channel index of out_data.
REQ-014 SHALL have ports out_valid  output  1 and out_ready  input  1  streaming handshake.
REQ-015 SHALL have ports busy  output  1 (state not IDLE) and frame_done  output  1 (single-cycle pulse).

Function
REQ-016 SHALL implement states IDLE, ERASE, EXPOSE, CONVERT, READ, STREAM with exactly one phase strobe high per matching state (erase/expose/convert/read); all strobes low in IDLE and STREAM.
REQ-017 SHALL move IDLE->ERASE on the edge where start=1; start SHALL be ignored in every other state.
REQ-018 SHALL hold ERASE for exactly ERASE_CYC cycles, then enter EXPOSE.
REQ-019 SHALL hold EXPOSE for the latched expose_cycles; a value of 0 SHALL be treated as 1.
REQ-020 SHALL hold CONVERT for exactly 2^DATA_W cycles; dac_data SHALL be 0 on the first CONVERT cycle, increment by 1 each cycle, reach 2^DATA_W-1 on the last, and be 0 in every other state.
REQ-021 SHALL hold READ for exactly 1 cycle and capture all N_PIX pix_bus words on the edge ending that cycle.
REQ-022 In STREAM, SHALL present the captured channels in order 0..N_PIX-1 with out_valid=1, advancing on each cycle with out_valid&&out_ready.
REQ-023 out_data and out_ch SHALL remain stable while out_valid=1 and out_ready=0; out_valid SHALL NOT drop without a handshake.
REQ-024 On the handshake of channel N_PIX-1: out_valid SHALL go low, frame_done SHALL pulse high for one cycle, and the state SHALL become ERASE if continuous=1, else IDLE.
REQ-025 With out_ready held high, STREAM SHALL last exactly N_PIX cycles.
REQ-026 Changes to expose_cycles during a frame SHALL NOT affect that frame.

Reset
REQ-027 When reset is asserted, the block SHALL enter IDLE immediately and asynchronously from any state, including mid-CONVERT or mid-STREAM.
REQ-028 During reset, all outputs SHALL be 0: strobes, dac_data, out_data, out_ch, out_valid, busy and frame_done.
REQ-029 During reset, the capture registers and latched exposure length SHALL be cleared to 0.
REQ-030 No frame SHALL start on the first edge after reset deassertion unless start=1 is sampled on that edge.

Configuration
REQ-031 Macro PIXEL_SEQ_FRAME_COUNT_EN defined: SHALL add output frame_cnt (16 bits), reset to 0, incremented on each frame_done, wrapping 65535->0.
REQ-032 Macro PIXEL_SEQ_FRAME_COUNT_EN undefined: frame_cnt port and logic SHALL be absent, with all other behaviour identical.

Verification (N_PIX=4, DATA_W=8, ERASE_CYC=5)
REQ-033 start pulse, expose_cycles=10, out_ready=1 -> erase 5 cycles, expose 10, convert 256, read 1, 4 stream beats, frame_done at cycle 276 after start; busy low afterwards.
REQ-034 pix_bus={8'h44,8'h33,8'h22,8'h11} at READ -> out_data 11,22,33,44 with out_ch 0..3.
REQ-035 out_ready low 3 cycles on channel 1 -> out_data=22 and out_ch=1 held stable; total stream length 7 cycles.
REQ-036 continuous=1 at frame end -> ERASE follows frame_done with no IDLE cycle; continuous=0 -> IDLE; expose_cycles=0 -> 1-cycle EXPOSE.
REQ-037 reset asserted at dac_data=100 -> all outputs 0 immediately; start during STREAM ignored.
REQ-038 With PIXEL_SEQ_FRAME_COUNT_EN, 3 frames -> frame_cnt=3; preload to 65535 then one frame -> 0.
